// File: rtl/keccak_pad_buffer_if.sv
// ============================================================================
// Module   : keccak_pad_buffer_if
// Brief    : Word-in / block-out bundle for keccak_pad_buffer.
//            KECCAK_PAD_MULTIRATE_EN adds the mode select.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface keccak_pad_buffer_if #(
  parameter int W = 64,
  parameter int R = 1088
);
  localparam int BW = (W > 8) ? $clog2(W / 8) : 1;

  logic [W-1:0]  in;
  logic          in_ready;
  logic          is_last;
  logic [BW-1:0] byte_num;
  logic          buffer_full;
  logic [R-1:0]  out;
  logic          out_ready;
  logic          out_last;
  logic          f_ack;
`ifdef KECCAK_PAD_MULTIRATE_EN
  logic [1:0]    mode;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack, mode,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack, mode,
    output buffer_full, out, out_ready, out_last
  );
`else
  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, out_last
  );
`endif

endinterface

`default_nettype wire

// File: rtl/keccak_pad_buffer.sv
// ============================================================================
// Module   : keccak_pad_buffer
// Brief    : Keccak sponge input padder / rate buffer. Packs W-bit words into
//            an R-bit block, appends domain byte and 0x80 pad bit, and holds
//            the block until the permutation acknowledges it.
//            Optional macro KECCAK_PAD_MULTIRATE_EN: mode-selected rate/domain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keccak_pad_buffer #(
  parameter int         W  = 64,
  parameter int         R  = 1088,
  parameter logic [7:0] DS = 8'h06
) (
  input wire logic           clk,
  input wire logic           reset,
  keccak_pad_buffer_if.slave bus
);

  localparam int c_NUM_WORDS = R / W;
  localparam int c_CW        = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
  localparam int c_BW        = (W > 8) ? $clog2(W / 8) : 1;
  localparam logic [W-1:0] c_PAD_END = W'(8'h80);

  localparam logic [1:0] c_ABSORB = 2'd0;
  localparam logic [1:0] c_PAD    = 2'd1;
  localparam logic [1:0] c_FULL   = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [R-1:0]    r_out;
  logic            r_out_ready;
  logic            r_out_last;

  logic [c_CW-1:0] w_last_idx;
  logic [7:0]      w_ds;
  logic            w_at_last;
  logic            w_accept;
  logic [W-1:0]    w_final_word;
  logic            w_wr_en;
  logic [W-1:0]    w_wr_word;
  logic            w_set_last;
  logic            w_clear;
  logic            w_buffer_full;

  assign w_accept  = (r_state == c_ABSORB) && bus.in_ready;
  assign w_at_last = (r_cnt == w_last_idx);

`ifdef KECCAK_PAD_MULTIRATE_EN
  // Mode is latched with the very first accepted word and kept until reset;
  // on that first word the live port value already selects the rate.
  logic [1:0] r_mode;
  logic       r_mode_held;
  logic [1:0] w_mode;

  assign w_mode = r_mode_held ? r_mode : bus.mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= 2'b00;
      r_mode_held <= 1'b0;
    end else if (w_accept && !r_mode_held) begin
      r_mode      <= bus.mode;
      r_mode_held <= 1'b1;
    end
  end

  always_comb begin
    w_last_idx = c_CW'(1088 / W - 1);
    w_ds       = 8'h06;
    case (w_mode)
      2'b01: begin
        w_last_idx = c_CW'(576 / W - 1);
        w_ds       = 8'h06;
      end
      2'b10: begin
        w_last_idx = c_CW'(1344 / W - 1);
        w_ds       = 8'h1F;
      end
      2'b11: begin
        w_last_idx = c_CW'(1088 / W - 1);
        w_ds       = 8'h1F;
      end
      default: begin
        w_last_idx = c_CW'(1088 / W - 1);
        w_ds       = 8'h06;
      end
    endcase
  end
`else
  assign w_last_idx = c_CW'(c_NUM_WORDS - 1);
  assign w_ds       = DS;
`endif

  // Final-word shaping, byte 0 is the MSB byte: keep, domain byte, then zeros.
  for (genvar b = 0; b < W / 8; b++) begin : g_byte
    localparam int c_HI = W - 1 - 8 * b;
    assign w_final_word[c_HI -: 8] =
        (c_BW'(b) <  bus.byte_num) ? bus.in[c_HI -: 8] :
        (c_BW'(b) == bus.byte_num) ? w_ds : 8'h00;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ABSORB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ABSORB: begin
        if (bus.in_ready) begin
          if (w_at_last) begin
            w_state_nxt = c_FULL;
          end else if (bus.is_last) begin
            w_state_nxt = c_PAD;
          end
        end
      end
      c_PAD: begin
        if (w_at_last) begin
          w_state_nxt = c_FULL;
        end
      end
      c_FULL: begin
        if (bus.f_ack) begin
          w_state_nxt = r_out_last ? c_DONE : c_ABSORB;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // FSM: outputs and datapath controls
  always_comb begin
    w_wr_en       = 1'b0;
    w_wr_word     = '0;
    w_set_last    = 1'b0;
    w_clear       = 1'b0;
    w_buffer_full = (r_state != c_ABSORB);
    case (r_state)
      c_ABSORB: begin
        w_wr_en    = bus.in_ready;
        w_set_last = bus.in_ready && bus.is_last && w_at_last;
        if (bus.is_last) begin
          w_wr_word = w_final_word | (w_at_last ? c_PAD_END : '0);
        end else begin
          w_wr_word = bus.in;
        end
      end
      c_PAD: begin
        w_wr_en    = 1'b1;
        w_set_last = w_at_last;
        w_wr_word  = w_at_last ? c_PAD_END : '0;
      end
      c_FULL: begin
        w_clear = bus.f_ack;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Block storage; the counter parks on the last slot until the block is acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out       <= '0;
      r_cnt       <= '0;
      r_out_ready <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_clear) begin
      r_out       <= '0;
      r_cnt       <= '0;
      r_out_ready <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_wr_en) begin
      for (int k = 0; k < c_NUM_WORDS; k++) begin
        if (r_cnt == c_CW'(k)) begin
          r_out[R - 1 - k * W -: W] <= w_wr_word;
        end
      end
      if (w_at_last) begin
        r_out_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
      if (w_set_last) begin
        r_out_last <= 1'b1;
      end
    end
  end

  assign bus.out         = r_out;
  assign bus.out_ready   = r_out_ready;
  assign bus.out_last    = r_out_last;
  assign bus.buffer_full = w_buffer_full;

endmodule

`default_nettype wire

// File: tb/tb_keccak_pad_buffer.sv
// ============================================================================
// Module   : tb_keccak_pad_buffer
// Brief    : Directed self-checking bench for keccak_pad_buffer (W=64).
//            With KECCAK_PAD_MULTIRATE_EN the buffer is 1344 bits wide.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keccak_pad_buffer;

`ifdef KECCAK_PAD_MULTIRATE_EN
  localparam int R_TB = 1344;
`else
  localparam int R_TB = 1088;
`endif
  localparam int W_TB = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  keccak_pad_buffer_if #(.W(W_TB), .R(R_TB)) bus ();

  keccak_pad_buffer #(.W(W_TB), .R(R_TB), .DS(8'h06)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] word_at(input int i);
    return bus.out[R_TB - 1 - 64 * i -: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] data, input logic last, input int bn);
    bus.in       = data;
    bus.is_last  = last;
    bus.byte_num = 3'(bn);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic ack();
    bus.f_ack = 1'b1;
    tick();
    bus.f_ack = 1'b0;
  endtask

  // Words 1..15 of a padded single-word message must all be zero.
  task automatic chk_mid_zero(input string tag, input int first, input int last);
    logic [63:0] acc;
    acc = '0;
    for (int i = first; i <= last; i++) acc |= word_at(i);
    chk(tag, acc, 64'h0);
  endtask

  task automatic case1_body(input string pfx);
    send(64'h646F672020202020, 1'b1, 3);
    chk({pfx, "_bf_edge1"}, 64'(bus.buffer_full), 64'h1);
    tick(15);
    chk({pfx, "_rdy_edge16"}, 64'(bus.out_ready), 64'h0);
    tick();
    chk({pfx, "_rdy_edge17"}, 64'(bus.out_ready), 64'h1);
    chk({pfx, "_w0"}, word_at(0), 64'h646F670600000000);
    chk_mid_zero({pfx, "_mid"}, 1, 15);
    chk({pfx, "_w16"}, word_at(16), 64'h0000000000000080);
    chk({pfx, "_last"}, 64'(bus.out_last), 64'h1);
    chk({pfx, "_bf"}, 64'(bus.buffer_full), 64'h1);
  endtask

  initial begin
    bus.in       = '0;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.byte_num = '0;
    bus.f_ack    = 1'b0;
`ifdef KECCAK_PAD_MULTIRATE_EN
    bus.mode     = 2'b00;
`endif
    tick(2);
    chk("rst_out_ready", 64'(bus.out_ready), 64'h0);
    chk("rst_out_last", 64'(bus.out_last), 64'h0);
    chk("rst_buffer_full", 64'(bus.buffer_full), 64'h0);
    chk("rst_out_zero", 64'(|bus.out), 64'h0);
    reset = 1'b1;
    tick();

    // Case 1: short message padded over 16 PAD cycles
    case1_body("c1");
    ack();
    chk("c1_done_bf", 64'(bus.buffer_full), 64'h1);
    chk("c1_done_rdy", 64'(bus.out_ready), 64'h0);
    chk("c1_done_last", 64'(bus.out_last), 64'h0);

    // Case 2: full non-final block, then back-pressure until ack
    do_reset();
    tick();
    bus.in_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in = 64'(i + 1);
      tick();
      if (i == 15) chk("c2_rdy_edge16", 64'(bus.out_ready), 64'h0);
    end
    chk("c2_rdy", 64'(bus.out_ready), 64'h1);
    chk("c2_last", 64'(bus.out_last), 64'h0);
    chk("c2_w0", word_at(0), 64'h1);
    chk("c2_w16", word_at(16), 64'h11);
    bus.in = 64'h12;
    tick(2);
    chk("c2_hold_w0", word_at(0), 64'h1);
    chk("c2_hold_w16", word_at(16), 64'h11);
    ack();
    chk("c2_ack_rdy", 64'(bus.out_ready), 64'h0);
    chk("c2_ack_w0", word_at(0), 64'h0);
    chk("c2_ack_bf", 64'(bus.buffer_full), 64'h0);
    tick();
    bus.in_ready = 1'b0;
    chk("c2_w18_w0", word_at(0), 64'h12);
    chk("c2_w18_w1", word_at(1), 64'h0);

    // Case 3: final word in the last slot, no PAD cycles
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) send(64'(8'hA0 + i), 1'b0, 0);
    chk("c3_rdy_pre", 64'(bus.out_ready), 64'h0);
    send(64'h0102030405060700, 1'b1, 7);
    chk("c3_rdy", 64'(bus.out_ready), 64'h1);
    chk("c3_last", 64'(bus.out_last), 64'h1);
    chk("c3_w15", word_at(15), 64'hAF);
    chk("c3_w16", word_at(16), 64'h0102030405060786);

    // Case 4: empty final word, then DONE ignores input
    do_reset();
    tick();
    send(64'hDEADBEEFCAFEF00D, 1'b1, 0);
    tick(16);
    chk("c4_rdy", 64'(bus.out_ready), 64'h1);
    chk("c4_w0", word_at(0), 64'h0600000000000000);
    chk("c4_w16", word_at(16), 64'h80);
    ack();
    bus.in       = 64'hFFFFFFFFFFFFFFFF;
    bus.in_ready = 1'b1;
    tick(3);
    bus.in_ready = 1'b0;
    chk("c4_done_bf", 64'(bus.buffer_full), 64'h1);
    chk("c4_done_w0", word_at(0), 64'h0);
    chk("c4_done_rdy", 64'(bus.out_ready), 64'h0);

    // Case 5: asynchronous reset in the middle of PAD
    do_reset();
    tick();
    send(64'h646F672020202020, 1'b1, 3);
    tick(4);
    reset = 1'b0;
    #1;
    chk("c5_async_rdy", 64'(bus.out_ready), 64'h0);
    chk("c5_async_bf", 64'(bus.buffer_full), 64'h0);
    chk("c5_async_out", 64'(|bus.out), 64'h0);
    #1;
    reset = 1'b1;
    tick();
    case1_body("c5");

`ifdef KECCAK_PAD_MULTIRATE_EN
    // Case 6: mode 01 selects a 576-bit rate in the upper buffer bits
    do_reset();
    tick();
    bus.mode = 2'b01;
    send(64'h1122334455667788, 1'b1, 0);
    bus.mode = 2'b00;
    tick(7);
    chk("c6_rdy_edge8", 64'(bus.out_ready), 64'h0);
    tick();
    chk("c6_rdy_edge9", 64'(bus.out_ready), 64'h1);
    chk("c6_w0", word_at(0), 64'h0600000000000000);
    chk("c6_bit775", 64'(bus.out[775]), 64'h1);
    chk("c6_w8", word_at(8), 64'h80);
    chk("c6_low_zero", 64'(|bus.out[767:0]), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keccak_pad_buffer.md
Name: keccak_pad_buffer

Overview:
Parametrised input padder and rate buffer for the Keccak sponge used by the Kyber hash/XOF paths (SHA3-256/512, SHAKE128/256).
- Packs W-bit message words into an R-bit rate block.
- Appends the domain-separation byte and the final 0x80 pad bit.
- Holds the finished block for the permutation core until it acknowledges.
- Replaces the fixed 64-bit / r=1088 / SHA3-only padder with configurable rate, word width and domain byte.

Parameters:
W, 64, input word width in bits; multiple of 8.
R, 1088, rate in bits; R % W == 0.
DS, 8'h06, domain-separation byte (8'h06 SHA3, 8'h1F SHAKE).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in  in  W  message word; byte 0 = in[W-1:W-8] (MSB-first).
in_ready  in  1  word valid.
is_last  in  1  current word is the final message word; qualified by in_ready.
byte_num  in  $clog2(W/8)  valid bytes in the final word, 0..W/8-1; ignored unless is_last.
buffer_full  out  1  block not accepting input.
out  out  R  rate block; word 0 at out[R-1 -: W].
out_ready  out  1  out holds a complete block.
out_last  out  1  held block is the final (padded) block.
f_ack  in  1  permutation consumed the block.

Behaviour:
- Reset (reset=0, any time, including mid-PAD or mid-FULL):
  - out=0, out_ready=0, out_last=0, buffer_full=0.
  - Word count = 0, state ABSORB.
- States:
  - ABSORB: accepting words.
  - PAD: zero-filling the remainder of the block.
  - FULL: block held for the permutation.
  - DONE: message finished.
- buffer_full = 1 in PAD, FULL and DONE; 0 in ABSORB.
- Word acceptance:
  - A word is accepted on an edge with in_ready=1 and state ABSORB; stored at word index cnt, then cnt increments.
  - is_last without in_ready is ignored.
  - in_ready while buffer_full=1 is dropped, not queued.
- Final word (is_last=1):
  - Bytes 0..byte_num-1 are kept from in.
  - Byte byte_num = DS; remaining bytes = 0.
  - byte_num = W/8-1 is legal; byte_num = W/8 is not. Padding therefore never spills into a new block.
- Completion paths:
  - Final word lands in the last block slot (cnt = R/W-1): its lowest byte is ORed with 0x80 (e.g. 0x06 becomes 0x86). Go to FULL with out_last=1.
  - Final word lands earlier: go to PAD. PAD writes one zero word per clock; the word at index R/W-1 is 64'h…80 (0x80 in its lowest byte). Then go to FULL with out_last=1.
  - Non-last word fills index R/W-1: go to FULL with out_last=0.
- out_ready rises on the same edge that stores word R/W-1; out is stable while out_ready=1.
- FULL:
  - Waits on f_ack.
  - On the edge with f_ack=1: out_ready→0, out cleared, cnt=0.
  - Then to ABSORB if out_last=0, else DONE (out_last cleared).
  - No word is accepted on the f_ack edge.
- f_ack outside FULL is ignored.
- DONE persists until reset.

Optional Feature:
KECCAK_PAD_MULTIRATE_EN
- Defined:
  - Adds input port mode[1:0], sampled when word 0 of the first block is accepted and held until reset.
  - Mode selects rate and domain byte, overriding DS:
    - 00: 1088 bits, 0x06.
    - 01: 576 bits, 0x06.
    - 10: 1344 bits, 0x1F.
    - 11: 1088 bits, 0x1F.
  - Requires R ≥ 1344.
  - The block occupies out[R-1 -: rate]; lower bits are 0.
  - Block completes at word rate/W-1; the 0x80 bit goes to out[R-rate+7].
- Undefined: no mode port; rate = R, domain byte = DS.

Test Plan:
1. Defaults; word 64'h646F672020202020 with is_last=1, byte_num=3 on edge 1 → PAD on edges 2..17; out_ready=1 after edge 17. out = {64'h646F670600000000, 15×64'h0, 64'h0000000000000080}; out_last=1, buffer_full=1.
2. 17 words 64'h1..64'h11 with in_ready held high → out_ready after edge 17, out_last=0. Word 18 is not taken until the edge after f_ack, and is then stored at out[1087:1024].
3. 16 words, then 17th word 64'h0102030405060700 with is_last=1, byte_num=7 → out_ready on that edge; out[63:0]=64'h0102030405060786, no PAD cycles.
4. First word with is_last=1, byte_num=0 → out[1087:1024]=64'h0600000000000000, out[63:0]=64'h80; after f_ack → DONE; buffer_full stays 1 and further in_ready is ignored.
5. reset low during PAD (edge 5) → out=0, out_ready=0, buffer_full=0 immediately, without waiting for a clock edge; a fresh case-1 message then reproduces case-1 output.
6. With KECCAK_PAD_MULTIRATE_EN, R=1344, mode=01, single word is_last=1, byte_num=0 → out_ready after 9 words; out[1343:1280]=64'h0600000000000000, out[775]=1, out[767:0]=0.
